// File: rtl/ila_capture_ctrl.sv
// ILA capture sequencer: flush, sliding pre-trigger window, post-trigger fill, valid/ready readout.
// Optional early trigger during the pre-fill phase is enabled by defining ILA_CAPTURE_EARLY_TRIG_EN.
module ila_capture_ctrl #(
  parameter int WIDTH        = 20,
  parameter int PRE_SAMPLES  = 16,
  parameter int POST_SAMPLES = 16,
  parameter int RD_LAT       = 2,
  parameter int FLUSH_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm_i,
  input  logic             trig_i,
  input  logic             sample_valid_i,
  input  logic [WIDTH-1:0] sample_i,
  output logic             fifo_rst_o,
  output logic             fifo_push_o,
  output logic [WIDTH-1:0] fifo_di_o,
  output logic             fifo_pop_o,
  input  logic [WIDTH-1:0] fifo_do_i,
  input  logic             fifo_full_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic [2:0]       state_o,
  output logic             capture_done_o,
  output logic             overflow_o
`ifdef ILA_CAPTURE_EARLY_TRIG_EN
  ,
  output logic             early_trig_o
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FLUSH = 3'd1;
  localparam logic [2:0] S_PRE   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_POST  = 3'd4;
  localparam logic [2:0] S_READ  = 3'd5;

  localparam logic [1:0] R_GUARD = 2'd0;
  localparam logic [1:0] R_POP   = 2'd1;
  localparam logic [1:0] R_WAIT  = 2'd2;
  localparam logic [1:0] R_HOLD  = 2'd3;

  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] PRE_N      = CNT_W'(PRE_SAMPLES);
  localparam logic [CNT_W-1:0] POST_N     = CNT_W'(POST_SAMPLES);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAT_LAST   = CNT_W'(RD_LAT - 1);
  localparam logic [2:0]       TRIG_NEXT  = (POST_SAMPLES == 1) ? S_READ : S_POST;

  logic [2:0]       state;
  logic [1:0]       rphase;
  logic [CNT_W-1:0] flush_cnt, pre_cnt, post_cnt, rd_cnt, lat_cnt, rd_total;
  logic             push_state, want_push, accept, early_hit;

  // With an empty window there is nothing to keep, so untriggered samples are not stored.
  assign push_state = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
  assign want_push  = sample_valid_i && push_state && !rst &&
                      !((state == S_WAIT) && !trig_i && (PRE_SAMPLES == 0));
  assign accept     = want_push && !fifo_full_i;
  assign rd_total   = pre_cnt + POST_N;

`ifdef ILA_CAPTURE_EARLY_TRIG_EN
  logic early_q;
  assign early_trig_o = early_q;
  assign early_hit    = (state == S_PRE) && trig_i;
`else
  assign early_hit    = 1'b0;
`endif

  assign fifo_di_o      = sample_i;
  assign fifo_push_o    = accept;
  assign fifo_pop_o     = !rst && (((state == S_WAIT) && accept && !trig_i) ||
                                   ((state == S_READ) && (rphase == R_POP)));
  assign fifo_rst_o     = rst || (state == S_FLUSH);
  assign state_o        = state;
  assign capture_done_o = (state == S_READ);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rphase     <= R_GUARD;
      flush_cnt  <= '0;
      pre_cnt    <= '0;
      post_cnt   <= '0;
      rd_cnt     <= '0;
      lat_cnt    <= '0;
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
      overflow_o <= 1'b0;
`ifdef ILA_CAPTURE_EARLY_TRIG_EN
      early_q    <= 1'b0;
`endif
    end else begin
      if (want_push && fifo_full_i) overflow_o <= 1'b1;
      case (state)
        S_IDLE: if (arm_i) begin
          state      <= S_FLUSH;
          rphase     <= R_GUARD;
          flush_cnt  <= '0;
          pre_cnt    <= '0;
          post_cnt   <= '0;
          rd_cnt     <= '0;
          lat_cnt    <= LAT_LAST;
          overflow_o <= 1'b0;
`ifdef ILA_CAPTURE_EARLY_TRIG_EN
          early_q    <= 1'b0;
`endif
        end
        S_FLUSH: begin
          if (flush_cnt == FLUSH_LAST) state <= (PRE_SAMPLES == 0) ? S_WAIT : S_PRE;
          else flush_cnt <= flush_cnt + ONE;
        end
        S_PRE: if (accept) begin
          if (early_hit) begin
            post_cnt <= ONE;
            state    <= TRIG_NEXT;
`ifdef ILA_CAPTURE_EARLY_TRIG_EN
            early_q  <= 1'b1;
`endif
          end else begin
            pre_cnt <= pre_cnt + ONE;
            if (pre_cnt + ONE == PRE_N) state <= S_WAIT;
          end
        end
        S_WAIT: if (accept && trig_i) begin
          post_cnt <= ONE;
          state    <= TRIG_NEXT;
        end
        S_POST: if (accept) begin
          post_cnt <= post_cnt + ONE;
          if (post_cnt + ONE == POST_N) state <= S_READ;
        end
        S_READ: begin
          // The entry guard lets any in-flight discarded window pops drain before the first fetch.
          case (rphase)
            R_GUARD: if (lat_cnt == '0) rphase <= R_POP; else lat_cnt <= lat_cnt - ONE;
            R_POP: begin
              lat_cnt <= LAT_LAST;
              rphase  <= R_WAIT;
            end
            R_WAIT: begin
              if (lat_cnt == '0) begin
                rd_data_o  <= fifo_do_i;
                rd_valid_o <= 1'b1;
                rphase     <= R_HOLD;
              end else lat_cnt <= lat_cnt - ONE;
            end
            default: if (rd_ready_i) begin
              rd_valid_o <= 1'b0;
              rd_cnt     <= rd_cnt + ONE;
              if (rd_cnt + ONE == rd_total) state <= S_IDLE;
              else rphase <= R_POP;
            end
          endcase
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ila_capture_ctrl.sv
// Directed bench for ila_capture_ctrl: PRE=4/POST=4 main instance, PRE=0/POST=1 corner instance.
module tb_ila_capture_ctrl;
  localparam int W = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, arm0, arm1, trig, sval, full, rdy0, rdy1;
  logic [W-1:0] smp;
  logic f_rst0, push0, pop0, rd_valid0, done0, ovf0;
  logic f_rst1, push1, pop1, rd_valid1, done1, ovf1;
  logic [W-1:0] di0, do0, rd_data0, di1, do1, rd_data1;
  logic [2:0] st0, st1;
`ifdef ILA_CAPTURE_EARLY_TRIG_EN
  logic early0, early1;
`endif

  ila_capture_ctrl #(.WIDTH(W), .PRE_SAMPLES(4), .POST_SAMPLES(4), .RD_LAT(2),
                     .FLUSH_CYCLES(4), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .arm_i(arm0), .trig_i(trig), .sample_valid_i(sval),
    .sample_i(smp), .fifo_rst_o(f_rst0), .fifo_push_o(push0), .fifo_di_o(di0),
    .fifo_pop_o(pop0), .fifo_do_i(do0), .fifo_full_i(full), .rd_data_o(rd_data0),
    .rd_valid_o(rd_valid0), .rd_ready_i(rdy0), .state_o(st0),
    .capture_done_o(done0), .overflow_o(ovf0)
`ifdef ILA_CAPTURE_EARLY_TRIG_EN
    , .early_trig_o(early0)
`endif
  );

  ila_capture_ctrl #(.WIDTH(W), .PRE_SAMPLES(0), .POST_SAMPLES(1), .RD_LAT(2),
                     .FLUSH_CYCLES(4), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .arm_i(arm1), .trig_i(trig), .sample_valid_i(sval),
    .sample_i(smp), .fifo_rst_o(f_rst1), .fifo_push_o(push1), .fifo_di_o(di1),
    .fifo_pop_o(pop1), .fifo_do_i(do1), .fifo_full_i(full), .rd_data_o(rd_data1),
    .rd_valid_o(rd_valid1), .rd_ready_i(rdy1), .state_o(st1),
    .capture_done_o(done1), .overflow_o(ovf1)
`ifdef ILA_CAPTURE_EARLY_TRIG_EN
    , .early_trig_o(early1)
`endif
  );

  // FIFO storage models with a two-stage read pipeline.
  logic [W-1:0] q0[$], q1[$];
  logic [W-1:0] p0[2], p1[2];
  assign do0 = p0[1];
  assign do1 = p1[1];

  always @(posedge clk) begin
    if (f_rst0) q0.delete();
    else begin
      if (pop0 && q0.size() > 0) p0[0] <= q0.pop_front();
      if (push0) q0.push_back(di0);
    end
    p0[1] <= p0[0];
  end

  always @(posedge clk) begin
    if (f_rst1) q1.delete();
    else begin
      if (pop1 && q1.size() > 0) p1[0] <= q1.pop_front();
      if (push1) q1.push_back(di1);
    end
    p1[1] <= p1[0];
  end

  int n_chk = 0;
  int n_pass = 0;
  int exp_w[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, act, exp);
  endtask

  task automatic wait_st0(input logic [2:0] s);
    int t = 0;
    while (st0 != s && t < 40) begin @(negedge clk); t++; end
    chk("wait_state", 32'(st0), 32'(s));
  endtask

  task automatic arm_u0();
    arm0 = 1'b1;
    @(negedge clk);
    arm0 = 1'b0;
    chk("flush_state", 32'(st0), 1);
    chk("flush_rst", 32'(f_rst0), 1);
    chk("ovf_cleared", 32'(ovf0), 0);
    wait_st0(3'd2);
  endtask

  task automatic feed(input int n, input bit tog, input int ta, input int tb2,
                      input int flo, input int fhi);
    for (int k = 1; k <= n; k++) begin
      smp  = W'(k);
      sval = tog ? k[0] : 1'b1;
      trig = (k == ta) || (k == tb2);
      full = (k >= flo) && (k <= fhi);
      if (full && sval) begin #1; chk("push_full", 32'(push0), 0); end
      @(negedge clk);
    end
    sval = 1'b0;
    trig = 1'b0;
    full = 1'b0;
  endtask

  task automatic read_words(input int n, input int stall, input bit last);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      while (!rd_valid0 && t < 30) begin @(negedge clk); t++; end
      chk("rd_valid", 32'(rd_valid0), 1);
      chk("rd_data", 32'(rd_data0), exp_w[i]);
      chk("done", 32'(done0), 1);
      if (i == 0) begin
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          chk("stall_valid", 32'(rd_valid0), 1);
          chk("stall_data", 32'(rd_data0), exp_w[0]);
          chk("stall_pop", 32'(pop0), 0);
        end
      end
      rdy0 = 1'b1;
      @(negedge clk);
      rdy0 = 1'b0;
    end
    if (last) begin
      chk("end_state", 32'(st0), 0);
      chk("end_done", 32'(done0), 0);
    end
  endtask

  initial begin
    rst = 1'b1; arm0 = 1'b0; arm1 = 1'b0; trig = 1'b0; sval = 1'b0;
    full = 1'b0; rdy0 = 1'b0; rdy1 = 1'b0; smp = '0;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(st0), 0);
    chk("rst_frst", 32'(f_rst0), 1);
    chk("rst_push", 32'(push0), 0);
    chk("rst_pop", 32'(pop0), 0);
    chk("rst_valid", 32'(rd_valid0), 0);
    chk("rst_ovf", 32'(ovf0), 0);
    chk("rst_done", 32'(done0), 0);
    chk("rst_state1", 32'(st1), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_frst", 32'(f_rst0), 0);

    // Basic capture, trigger on sample 12.
    arm_u0();
    feed(20, 1'b0, 12, 0, 0, 0);
    exp_w = '{8, 9, 10, 11, 12, 13, 14, 15};
    read_words(8, 0, 1'b1);
`ifdef ILA_CAPTURE_EARLY_TRIG_EN
    chk("early_off", 32'(early0), 0);
`endif

    // Alternating valid; trigger on invalid sample 14 must be ignored.
    arm_u0();
    feed(26, 1'b1, 17, 14, 0, 0);
    exp_w = '{9, 11, 13, 15, 17, 19, 21, 23};
    read_words(8, 0, 1'b1);

    // Consumer backpressure on the first word.
    arm_u0();
    feed(20, 1'b0, 12, 0, 0, 0);
    exp_w = '{8, 9, 10, 11, 12, 13, 14, 15};
    read_words(8, 10, 1'b1);

    // FIFO full for three POST samples.
    arm_u0();
    feed(24, 1'b0, 12, 0, 13, 15);
    chk("ovf_set", 32'(ovf0), 1);
    exp_w = '{8, 9, 10, 11, 12, 16, 17, 18};
    read_words(8, 0, 1'b1);
    chk("ovf_sticky", 32'(ovf0), 1);

    // Reset during POST.
    arm_u0();
    feed(14, 1'b0, 12, 0, 0, 0);
    chk("in_post", 32'(st0), 4);
    rst = 1'b1;
    #1;
    chk("rst_post_frst", 32'(f_rst0), 1);
    @(negedge clk);
    chk("rst_post_state", 32'(st0), 0);
    chk("rst_post_valid", 32'(rd_valid0), 0);
    rst = 1'b0;
    @(negedge clk);

    // Reset mid-READ, with a fetch about to be issued.
    arm_u0();
    feed(20, 1'b0, 12, 0, 0, 0);
    exp_w = '{8, 9, 10, 11, 12, 13, 14, 15};
    read_words(3, 0, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_read_pop", 32'(pop0), 0);
    chk("rst_read_frst", 32'(f_rst0), 1);
    @(negedge clk);
    chk("rst_read_state", 32'(st0), 0);
    chk("rst_read_valid", 32'(rd_valid0), 0);
    rst = 1'b0;
    @(negedge clk);
    arm_u0();
    feed(20, 1'b0, 12, 0, 0, 0);
    read_words(8, 0, 1'b1);

    // PRE=0, POST=1: single trigger word.
    arm1 = 1'b1;
    @(negedge clk);
    arm1 = 1'b0;
    begin
      int t = 0;
      while (st1 != 3'd3 && t < 40) begin @(negedge clk); t++; end
      chk("u1_wait_state", 32'(st1), 3);
    end
    feed(8, 1'b0, 5, 0, 0, 0);
    begin
      int t = 0;
      while (!rd_valid1 && t < 30) begin @(negedge clk); t++; end
      chk("u1_valid", 32'(rd_valid1), 1);
      chk("u1_data", 32'(rd_data1), 5);
    end
    rdy1 = 1'b1;
    @(negedge clk);
    rdy1 = 1'b0;
    chk("u1_end_state", 32'(st1), 0);
    chk("u1_end_valid", 32'(rd_valid1), 0);

`ifdef ILA_CAPTURE_EARLY_TRIG_EN
    // Early trigger on the second pre-window sample.
    arm_u0();
    feed(12, 1'b0, 2, 0, 0, 0);
    exp_w = '{1, 2, 3, 4, 5};
    read_words(5, 0, 1'b1);
    chk("early_flag", 32'(early0), 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
